// File: rtl/cpu_pkg.sv
// Shared definitions for the 19-bit CPU front end: redirect opcodes,
// sequencer state encodings and the default address width.
package cpu_pkg;

    localparam int AW_DEFAULT = 19;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_BR   = 3'd1;
    localparam logic [2:0] OP_JMP  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;
    localparam logic [2:0] OP_HALT = 3'd5;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry; the top entry is read combinationally.
module pc_ras #(
    parameter int AW        = 19,
    parameter int RAS_DEPTH = 8,
    localparam int PW       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1,
    localparam int CW       = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [AW-1:0] push_data_i,
    output logic [AW-1:0] top_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [AW-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0] sp_q, sp_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] top_idx;

    // sp_q points at the next slot to write; the top lives one below it.
    assign top_idx = sp_q - PW'(1);
    assign top_o   = mem_q[top_idx];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(RAS_DEPTH));
    assign empty_o = (count_q == '0);

    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        if (push_i) begin
            sp_d = sp_q + PW'(1);
            if (!full_o) begin
                count_d = count_q + CW'(1);
            end
        end else if (pop_i && !empty_o) begin
            sp_d    = top_idx;
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q    <= '0;
            count_q <= '0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[sp_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: presents fetch addresses over valid/ready and
// applies branch/jump/call/return/halt redirects from execute.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int            AW        = AW_DEFAULT,
    parameter logic [AW-1:0] RESET_VEC = '0,
    parameter int            RAS_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          fetch_valid,
    input  logic          fetch_ready,
    output logic [AW-1:0] fetch_addr,
    input  logic          redir_valid,
    input  logic [2:0]    redir_op,
    input  logic [AW-1:0] redir_pc,
    input  logic [AW-1:0] redir_imm,
    output logic          flush,
    output logic          halted,
    output logic          err_unf,
    output logic          ras_ovf,
    output logic [1:0]    dbg_state
);

    // Fetch handshake: a request transfers on any rising edge where
    // fetch_valid && fetch_ready; redirects have no ready and always land.

    localparam int CW = ((RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1) + 1;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          flush_q, flush_d;
    logic          err_unf_q, err_unf_d;
    logic          ras_ovf_q, ras_ovf_d;

    logic          ras_push, ras_pop;
    logic [AW-1:0] ras_top;
    logic [CW-1:0] ras_count;
    logic          ras_full, ras_empty;

    pc_ras #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (redir_pc + AW'(1)),
        .top_o       (ras_top),
        .count_o     (ras_count),
        .full_o      (ras_full),
        .empty_o     (ras_empty)
    );

    assign fetch_valid = (state_q == ST_RUN);
    assign fetch_addr  = pc_q;
    assign flush       = flush_q;
    assign halted      = (state_q == ST_HALT);
    assign err_unf     = err_unf_q;
    assign ras_ovf     = ras_ovf_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        flush_d   = 1'b0;
        err_unf_d = err_unf_q;
        ras_ovf_d = ras_ovf_q;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (fetch_ready) begin
                    pc_d = pc_q + AW'(1);
                end
                // A redirect overrides the sequential advance in the same cycle.
                if (redir_valid) begin
                    case (redir_op)
                        OP_BR: begin
                            pc_d    = redir_pc + redir_imm;
                            flush_d = 1'b1;
                        end
                        OP_JMP: begin
                            pc_d    = redir_imm;
                            flush_d = 1'b1;
                        end
                        OP_CALL: begin
                            pc_d     = redir_imm;
                            flush_d  = 1'b1;
                            ras_push = 1'b1;
                            if (ras_full) begin
                                ras_ovf_d = 1'b1;
                            end
                        end
                        OP_RET: begin
                            flush_d = 1'b1;
                            if (ras_empty) begin
                                pc_d      = pc_q;
                                err_unf_d = 1'b1;
                                state_d   = ST_HALT;
                            end else begin
                                pc_d    = ras_top;
                                ras_pop = 1'b1;
                            end
                        end
                        OP_HALT: begin
                            pc_d    = pc_q;
                            flush_d = 1'b1;
                            state_d = ST_HALT;
                        end
                        default: ;
                    endcase
                end
            end
            ST_HALT: ;
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_VEC;
            flush_q   <= 1'b0;
            err_unf_q <= 1'b0;
            ras_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            flush_q   <= flush_d;
            err_unf_q <= err_unf_d;
            ras_ovf_q <= ras_ovf_d;
        end
    end

    logic unused_count;
    assign unused_count = ^ras_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: accepted fetch addresses are checked
// against an expected queue, flags and redirect targets against constants.
module tb_pc_sequencer;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [18:0] fetch_addr;
  logic        redir_valid;
  logic [2:0]  redir_op;
  logic [18:0] redir_pc;
  logic [18:0] redir_imm;
  logic        flush;
  logic        halted;
  logic        err_unf;
  logic        ras_ovf;
  logic [1:0]  dbg_state;

  int total;
  int bad;
  logic [18:0] exp_q[$];
  logic [18:0] mon_exp;

  pc_sequencer #(
    .AW        (19),
    .RESET_VEC (19'h00000),
    .RAS_DEPTH (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_addr  (fetch_addr),
    .redir_valid (redir_valid),
    .redir_op    (redir_op),
    .redir_pc    (redir_pc),
    .redir_imm   (redir_imm),
    .flush       (flush),
    .halted      (halted),
    .err_unf     (err_unf),
    .ras_ovf     (ras_ovf),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every accepted fetch must match the next expected address
  always @(negedge clk) begin
    if (rst_n && fetch_valid && fetch_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_fetch: got 0x%0h expected none", fetch_addr);
      end else begin
        mon_exp = exp_q.pop_front();
        if (fetch_addr !== mon_exp) begin
          bad++;
          $display("FAIL fetch_addr: got 0x%0h expected 0x%0h", fetch_addr, mon_exp);
        end
      end
    end
  end

  task automatic redirect(input string name, input logic [2:0] op, input logic [18:0] rpc,
                          input logic [18:0] imm, input logic [18:0] exp_addr, input logic exp_flush);
    redir_valid = 1'b1;
    redir_op    = op;
    redir_pc    = rpc;
    redir_imm   = imm;
    step();
    redir_valid = 1'b0;
    fetch_ready = 1'b0;
    check({name, "_addr"}, fetch_addr, exp_addr);
    check({name, "_flush"}, flush, exp_flush);
    step();
    check({name, "_flush_drop"}, flush, 1'b0);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    fetch_ready = 1'b1;
    redir_valid = 1'b0;
    redir_op    = OP_NONE;
    redir_pc    = '0;
    redir_imm   = '0;
    step();
    step();
    check("rst_valid", fetch_valid, 1'b0);
    check("rst_addr", fetch_addr, 19'h00000);
    check("rst_flush", flush, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_err_unf", err_unf, 1'b0);
    check("rst_ras_ovf", ras_ovf, 1'b0);

    // release: one BOOT cycle, then sequential fetch 0,1,2,3
    rst_n = 1'b1;
    check("boot_state", dbg_state, ST_BOOT);
    check("boot_valid", fetch_valid, 1'b0);
    exp_q.push_back(19'h00000);
    exp_q.push_back(19'h00001);
    exp_q.push_back(19'h00002);
    exp_q.push_back(19'h00003);
    step();
    check("run_state", dbg_state, ST_RUN);
    check("run_valid", fetch_valid, 1'b1);
    repeat (4) step();
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_addr", fetch_addr, 19'h00004);
      step();
    end

    // relative branches with wrap-around
    redirect("br_back", OP_BR, 19'h00010, 19'h7FFF0, 19'h00000, 1'b1);
    redirect("br_wrap", OP_BR, 19'h7FFFF, 19'h00001, 19'h00000, 1'b1);

    // jump racing a handshake on address 0
    fetch_ready = 1'b1;
    exp_q.push_back(19'h00000);
    redirect("jmp_race", OP_JMP, 19'h00000, 19'h01234, 19'h01234, 1'b1);
    fetch_ready = 1'b1;
    exp_q.push_back(19'h01234);
    step();
    fetch_ready = 1'b0;
    check("post_jmp_addr", fetch_addr, 19'h01235);

    // no-effect opcodes
    redirect("op_none", OP_NONE, 19'h00100, 19'h00555, 19'h01235, 1'b0);
    redirect("op_six", 3'd6, 19'h00100, 19'h00555, 19'h01235, 1'b0);

    // nested call / return
    redirect("call1", OP_CALL, 19'h00100, 19'h00200, 19'h00200, 1'b1);
    redirect("call2", OP_CALL, 19'h00205, 19'h00300, 19'h00300, 1'b1);
    redirect("ret1", OP_RET, 19'h00300, 19'h00000, 19'h00206, 1'b1);
    redirect("ret2", OP_RET, 19'h00206, 19'h00000, 19'h00101, 1'b1);

    // nine calls overflow an eight-entry stack
    for (int i = 0; i < 9; i++) begin
      redirect("call_ovf", OP_CALL, 19'(19'h01000 + i * 16), 19'(19'h02000 + i),
               19'(19'h02000 + i), 1'b1);
      if (i == 7) check("ras_ovf_at8", ras_ovf, 1'b0);
    end
    check("ras_ovf_at9", ras_ovf, 1'b1);
    for (int i = 8; i >= 1; i--) begin
      redirect("ret_ovf", OP_RET, 19'h00000, 19'h00000, 19'(19'h01001 + i * 16), 1'b1);
    end
    check("ras_ovf_sticky", ras_ovf, 1'b1);
    check("err_unf_before", err_unf, 1'b0);

    // underflow halts
    redir_valid = 1'b1;
    redir_op    = OP_RET;
    step();
    redir_valid = 1'b0;
    check("unf_err", err_unf, 1'b1);
    check("unf_halted", halted, 1'b1);
    check("unf_valid", fetch_valid, 1'b0);
    check("unf_addr", fetch_addr, 19'h01011);
    check("unf_state", dbg_state, ST_HALT);
    step();

    // redirects ignored in HALT
    fetch_ready = 1'b1;
    redirect("halt_jmp", OP_JMP, 19'h00000, 19'h00555, 19'h01011, 1'b0);
    check("halt_stays", halted, 1'b1);

    // reset out of HALT wins over a pending redirect
    rst_n       = 1'b0;
    redir_valid = 1'b1;
    redir_op    = OP_JMP;
    redir_imm   = 19'h00777;
    step();
    check("rst2_valid", fetch_valid, 1'b0);
    check("rst2_addr", fetch_addr, 19'h00000);
    check("rst2_halted", halted, 1'b0);
    check("rst2_err_unf", err_unf, 1'b0);
    check("rst2_ras_ovf", ras_ovf, 1'b0);
    check("rst2_flush", flush, 1'b0);

    // redirect during BOOT is ignored
    rst_n = 1'b1;
    step();
    redir_valid = 1'b0;
    check("boot_ign_addr", fetch_addr, 19'h00000);
    check("boot_ign_flush", flush, 1'b0);
    check("boot_ign_valid", fetch_valid, 1'b1);

    // empty stack after reset: RET underflows
    redirect("ret_after_rst", OP_RET, 19'h00000, 19'h00000, 19'h00000, 1'b1);
    check("ret_after_rst_err", err_unf, 1'b1);

    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
